input_debounce: RTL and testbench



---
 rtl/input_debounce_if.sv | 32 +++
 rtl/input_debounce.sv | 78 +++++++
 tb/tb_input_debounce.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/input_debounce_if.sv
// ============================================================================
// Module      : input_debounce_if
// Description : Raw pin inputs and conditioned outputs of the debounce stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface input_debounce_if;
    logic [15:0] SwRaw;
    logic [2:0]  BtnRaw;
    logic [15:0] Sw;
    logic [2:0]  Btn;
    logic [2:0]  BtnPress;

    modport master (
        output SwRaw,
        output BtnRaw,
        input  Sw,
        input  Btn,
        input  BtnPress
    );

    modport slave (
        input  SwRaw,
        input  BtnRaw,
        output Sw,
        output Btn,
        output BtnPress
    );
endinterface

`default_nettype wire

// File: rtl/input_debounce.sv
// ============================================================================
// Module      : input_debounce
// Description : Synchronizes and debounces 16 switches and 3 active-low buttons,
//               with a one-cycle strobe on each debounced button press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input wire              Clk,
    input wire              Rst,
    input_debounce_if.slave bus
);

    localparam int                c_num_ch   = 19;
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Buttons idle released (high), switches idle low.
    localparam logic [c_num_ch-1:0] c_rst_val = {3'b111, 16'h0000};

    logic [c_num_ch-1:0] w_raw;
    logic [c_num_ch-1:0] w_stable;
    logic [c_num_ch-1:0] w_stable_nxt;
    logic [2:0]          r_press;

    assign w_raw = {bus.BtnRaw, bus.SwRaw};

    for (genvar gi = 0; gi < c_num_ch; gi++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic             r_stable;
        logic [CNT_W-1:0] r_cnt;
        logic             w_mismatch;
        logic             w_done;

        assign w_mismatch       = r_sync2 ^ r_stable;
        assign w_done           = w_mismatch && (r_cnt == c_cnt_last);
        assign w_stable[gi]     = r_stable;
        assign w_stable_nxt[gi] = w_done ? r_sync2 : r_stable;

        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_sync1  <= c_rst_val[gi];
                r_sync2  <= c_rst_val[gi];
                r_stable <= c_rst_val[gi];
                r_cnt    <= '0;
            end else begin
                r_sync1  <= w_raw[gi];
                r_sync2  <= r_sync1;
                r_stable <= w_stable_nxt[gi];
                // Any agreement or a completed run restarts the count.
                if (!w_mismatch || w_done) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Strobe lands on the same edge the debounced level falls.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_press <= 3'b000;
        end else begin
            r_press <= w_stable[18:16] & ~w_stable_nxt[18:16];
        end
    end

    assign bus.Sw       = w_stable[15:0];
    assign bus.Btn      = w_stable[18:16];
    assign bus.BtnPress = r_press;

endmodule

`default_nettype wire

// File: tb/tb_input_debounce.sv
// ============================================================================
// Module      : tb_input_debounce
// Description : Directed self-checking bench for input_debounce (4-cycle filter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debounce;

    typedef struct packed {
        logic        rst;
        logic [15:0] sw;
        logic [2:0]  btn;
        logic [15:0] esw;
        logic [2:0]  ebtn;
        logic [2:0]  epress;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];

    input_debounce_if bus();

    input_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [15:0] sw, input logic [2:0] btn,
                       input logic [15:0] esw, input logic [2:0] ebtn, input logic [2:0] epress);
        vec_t v;
        v.rst = r; v.sw = sw; v.btn = btn;
        v.esw = esw; v.ebtn = ebtn; v.epress = epress;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] esw,
                         input logic [2:0] ebtn, input logic [2:0] epress);
        n_checks++;
        if (bus.Sw === esw && bus.Btn === ebtn && bus.BtnPress === epress) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got Sw=%h Btn=%b BtnPress=%b, expected Sw=%h Btn=%b BtnPress=%b",
                     name, bus.Sw, bus.Btn, bus.BtnPress, esw, ebtn, epress);
        end
    endtask

    // Drive new raw levels, expect old outputs through E5, new at E6, strobe gone at E7.
    task automatic settle(input string name, input logic [15:0] sw, input logic [2:0] btn,
                          input logic [15:0] osw, input logic [2:0] obtn,
                          input logic [15:0] nsw, input logic [2:0] nbtn, input logic [2:0] npress);
        rst = 1'b0;
        bus.SwRaw  = sw;
        bus.BtnRaw = btn;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("%s_E%0d", name, k), osw, obtn, 3'b000);
        end
        step();
        check($sformatf("%s_E6", name), nsw, nbtn, npress);
        step();
        check($sformatf("%s_E7", name), nsw, nbtn, 3'b000);
    endtask

    initial begin
        logic [2:0] bounce [10];
        n_checks = 0;
        n_pass   = 0;
        rst        = 1'b1;
        bus.SwRaw  = 16'hFFFF;
        bus.BtnRaw = 3'b000;

        // Reset, then raw FFFF/000 propagating out at the sixth edge after release.
        add(1'b1, 16'hFFFF, 3'b000, 16'h0000, 3'b111, 3'b000);
        add(1'b1, 16'hFFFF, 3'b000, 16'h0000, 3'b111, 3'b000);
        for (int k = 0; k < 5; k++) add(1'b0, 16'hFFFF, 3'b000, 16'h0000, 3'b111, 3'b000);
        add(1'b0, 16'hFFFF, 3'b000, 16'hFFFF, 3'b000, 3'b111);
        add(1'b0, 16'hFFFF, 3'b000, 16'hFFFF, 3'b000, 3'b000);
        // Everything back to idle: releases give no strobe.
        for (int k = 0; k < 5; k++) add(1'b0, 16'h0000, 3'b111, 16'hFFFF, 3'b000, 3'b000);
        add(1'b0, 16'h0000, 3'b111, 16'h0000, 3'b111, 3'b000);
        // Clean switch change 0000 -> A55A.
        for (int k = 0; k < 5; k++) add(1'b0, 16'hA55A, 3'b111, 16'h0000, 3'b111, 3'b000);
        add(1'b0, 16'hA55A, 3'b111, 16'hA55A, 3'b111, 3'b000);
        add(1'b0, 16'hA55A, 3'b111, 16'hA55A, 3'b111, 3'b000);

        foreach (vecs[i]) begin
            rst        = vecs[i].rst;
            bus.SwRaw  = vecs[i].sw;
            bus.BtnRaw = vecs[i].btn;
            step();
            check($sformatf("vec%0d", i), vecs[i].esw, vecs[i].ebtn, vecs[i].epress);
        end

        // Bounce on button 1: never four consecutive lows after sync.
        bounce = '{3'b111, 3'b101, 3'b111, 3'b101, 3'b101, 3'b111,
                   3'b111, 3'b111, 3'b111, 3'b111};
        for (int k = 0; k < 10; k++) begin
            bus.BtnRaw = bounce[k];
            step();
            check($sformatf("bounce%0d", k), 16'hA55A, 3'b111, 3'b000);
        end
        settle("press1", 16'hA55A, 3'b101, 16'hA55A, 3'b111, 16'hA55A, 3'b101, 3'b010);
        settle("release1", 16'hA552, 3'b111, 16'hA55A, 3'b101, 16'hA552, 3'b111, 3'b000);
        settle("simul", 16'hA55A, 3'b010, 16'hA552, 3'b111, 16'hA55A, 3'b010, 3'b101);
        settle("idle", 16'hA55A, 3'b111, 16'hA55A, 3'b010, 16'hA55A, 3'b111, 3'b000);

        // Reset pulse aborts a partial count on button 0.
        bus.BtnRaw = 3'b110;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("midcnt%0d", k), 16'hA55A, 3'b111, 3'b000);
        end
        rst = 1'b1;
        step();
        check("midrst", 16'h0000, 3'b111, 3'b000);
        settle("postrst", 16'hA55A, 3'b110, 16'h0000, 3'b111, 16'hA55A, 3'b110, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
